query_decode: RTL

//   Bit-serial decoder for the Gen2 Query command, directly upstream of the tx-settings

---
 rtl/query_decode.sv | 121 ++++++++++++
 1 files changed

// File: rtl/query_decode.sv
// query_decode: bit-serial Gen2 Query decoder with opcode and CRC-5 check feeding the tx-settings register
module query_decode #(
    parameter int         TRCAL_W    = 10,
    parameter logic [4:0] CRC_PRESET = 5'b01001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_start,
    input  logic [TRCAL_W-1:0] trcal_meas,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               dr_out,
    output logic [1:0]         m_out,
    output logic               trext_out,
    output logic [1:0]         sel_out,
    output logic [1:0]         session_out,
    output logic               target_out,
    output logic [3:0]         q_out,
    output logic [TRCAL_W-1:0] trcal_out,
    output logic               query_complete,
    output logic               crc_error
);
    typedef enum logic [2:0] {IDLE, OPC, BODY, CRC, DONE, ABORT} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [12:0]        shadow_q, shadow_d;
    logic [4:0]         crc_q, crc_d;
    logic [TRCAL_W-1:0] trcal_sh_q, trcal_sh_d;
    logic [12:0]        fields_q, fields_d;
    logic [TRCAL_W-1:0] trcal_q, trcal_d;
    logic               qc_q, qc_d;
    logic               err_q, err_d;
    logic               fb;
    logic [4:0]         crc_next;

    assign fb       = bit_in ^ crc_q[4];
    assign crc_next = {crc_q[3], crc_q[2] ^ fb, crc_q[1], crc_q[0], fb};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        crc_d      = crc_q;
        trcal_sh_d = trcal_sh_q;
        fields_d   = fields_q;
        trcal_d    = trcal_q;
        qc_d       = 1'b0;
        err_d      = 1'b0;
        if (cmd_start) begin
            state_d    = OPC;
            cnt_d      = 5'd0;
            shadow_d   = 13'd0;
            crc_d      = CRC_PRESET;
            trcal_sh_d = trcal_meas;
        end else begin
            case (state_q)
                OPC: if (bit_valid) begin
                    crc_d = crc_next;
                    cnt_d = cnt_q + 5'd1;
                    // opcode 1000: only bit 0 is a one
                    if (bit_in != (cnt_q == 5'd0))
                        state_d = ABORT;
                    else if (cnt_q == 5'd3)
                        state_d = BODY;
                end
                BODY: if (bit_valid) begin
                    crc_d    = crc_next;
                    cnt_d    = cnt_q + 5'd1;
                    shadow_d = {shadow_q[11:0], bit_in};
                    state_d  = (cnt_q == 5'd16) ? CRC : BODY;
                end
                CRC: if (bit_valid) begin
                    crc_d   = crc_next;
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd21) ? DONE : CRC;
                end
                DONE: begin
                    state_d = IDLE;
                    if (crc_q == 5'd0) begin
                        fields_d = shadow_q;
                        trcal_d  = trcal_sh_q;
                        qc_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            shadow_q   <= 13'd0;
            crc_q      <= CRC_PRESET;
            trcal_sh_q <= '0;
            fields_q   <= 13'd0;
            trcal_q    <= '0;
            qc_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            crc_q      <= crc_d;
            trcal_sh_q <= trcal_sh_d;
            fields_q   <= fields_d;
            trcal_q    <= trcal_d;
            qc_q       <= qc_d;
            err_q      <= err_d;
        end
    end

    assign {dr_out, m_out, trext_out, sel_out, session_out, target_out, q_out} = fields_q;
    assign trcal_out      = trcal_q;
    assign query_complete = qc_q;
    assign crc_error      = err_q;
endmodule
